// File: rtl/fcp_pkg.sv
// fcp_pkg: shared definitions for the FCP TX frame scheduler.
//   fcp_state_e   scheduler FSM states (IDLE / BUSY / GAP)
//   TX_TYPE_*     encoding of the tx_type output toward the TX controller
//   UI_CYCLE      default unit-interval length in clock cycles
package fcp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } fcp_state_e;

  localparam logic TX_TYPE_PING = 1'b0;
  localparam logic TX_TYPE_DATA = 1'b1;

  localparam int UI_CYCLE = 20;

endpackage

// File: rtl/fcp_tx_timer.sv
// fcp_tx_timer: shared up-counter for BUSY watchdog and GAP timing.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (count -> 0)
//   clr_i      synchronous clear (count -> 0), wins over enable
//   en_i       count enable
//   busy_hit_o count == BUSY_LAST (last cycle allowed in BUSY)
//   gap_hit_o  count == GAP_LAST  (last cycle of the inter-frame gap)
// The counter saturates at all-ones instead of wrapping.
module fcp_tx_timer #(
  parameter int CNT_W     = 16,
  parameter int BUSY_LAST = 4095,
  parameter int GAP_LAST  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic busy_hit_o,
  output logic gap_hit_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy_hit_o = (cnt_q == CNT_W'(BUSY_LAST));
  assign gap_hit_o  = (cnt_q == CNT_W'(GAP_LAST));

endmodule

// File: rtl/fcp_tx_sched.sv
// fcp_tx_sched: frame scheduler in front of the FCP TX controller.
// Arbitrates ping vs. data-response requests (response has fixed priority),
// drives the level-sensitive tx_en with stable frame fields, waits for
// tx_done, enforces an inter-frame gap and runs a completion watchdog.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ping_req / ping_gnt         ping request level / 1-cycle accept pulse
//   rsp_req / rsp_gnt           response request level / 1-cycle accept pulse
//   rsp_afc, rsp_data           response fields, captured at accept
//   cfg_tune_up, cfg_tune_cycle UI tune settings, latched at accept
//   tx_en, tx_type, tx_afc,     frame toward the TX controller (fields
//   tx_data, tune_up,           stable while tx_en=1)
//   tune_cycle
//   tx_done                     end-of-frame pulse from the TX controller
//   frame_done, frame_err       completion / watchdog-exhausted pulses
//   busy                        1 whenever the FSM is not IDLE
// Build option: define FCP_TX_RETRY_EN to relaunch a timed-out frame up to
// MAX_RETRY times before frame_err is raised.
module fcp_tx_sched
  import fcp_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
`ifdef FCP_TX_RETRY_EN
  parameter int MAX_RETRY      = 2,
`endif
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ping_req,
  output logic        ping_gnt,
  input  logic        rsp_req,
  input  logic        rsp_afc,
  input  logic [15:0] rsp_data,
  output logic        rsp_gnt,
  input  logic        cfg_tune_up,
  input  logic [7:0]  cfg_tune_cycle,
  output logic        tx_en,
  output logic        tx_type,
  output logic        tx_afc,
  output logic [15:0] tx_data,
  output logic        tune_up,
  output logic [7:0]  tune_cycle,
  input  logic        tx_done,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  fcp_state_e  state_q;
  logic        ping_gnt_q, rsp_gnt_q, tx_en_q, tx_type_q, tx_afc_q;
  logic [15:0] tx_data_q;
  logic        tune_up_q;
  logic [7:0]  tune_cycle_q;
  logic        frame_done_q, frame_err_q, busy_q;

  logic busy_hit, gap_hit, timer_clr, timer_en;

`ifdef FCP_TX_RETRY_EN
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q;
  logic               relaunch_q;  // current GAP ends in a relaunch, not IDLE
`endif

  // Counter is held at 0 in IDLE and cleared on every state change, so it
  // always starts from 0 in the first cycle of BUSY and of GAP.
  assign timer_en  = (state_q != ST_IDLE);
  assign timer_clr = (state_q == ST_IDLE)
                   || ((state_q == ST_BUSY) && (tx_done || busy_hit))
                   || ((state_q == ST_GAP) && gap_hit);

  fcp_tx_timer #(
    .CNT_W    (CNT_W),
    .BUSY_LAST(TIMEOUT_CYCLES - 1),
    .GAP_LAST (GAP_CYCLES - 1)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .busy_hit_o(busy_hit),
    .gap_hit_o (gap_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ping_gnt_q   <= 1'b0;
      rsp_gnt_q    <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_type_q    <= 1'b0;
      tx_afc_q     <= 1'b0;
      tx_data_q    <= '0;
      tune_up_q    <= 1'b0;
      tune_cycle_q <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FCP_TX_RETRY_EN
      retry_q      <= '0;
      relaunch_q   <= 1'b0;
`endif
    end else begin
      // pulse outputs default low
      ping_gnt_q   <= 1'b0;
      rsp_gnt_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rsp_req || ping_req) begin
            state_q      <= ST_BUSY;
            tx_en_q      <= 1'b1;
            busy_q       <= 1'b1;
            tune_up_q    <= cfg_tune_up;
            tune_cycle_q <= cfg_tune_cycle;
`ifdef FCP_TX_RETRY_EN
            retry_q      <= '0;
            relaunch_q   <= 1'b0;
`endif
            if (rsp_req) begin
              rsp_gnt_q <= 1'b1;
              tx_type_q <= TX_TYPE_DATA;
              tx_afc_q  <= rsp_afc;
              tx_data_q <= rsp_data;
            end else begin
              // ping keeps the previous payload on tx_data
              ping_gnt_q <= 1'b1;
              tx_type_q  <= TX_TYPE_PING;
              tx_afc_q   <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          // tx_done is tested first so it wins over a same-cycle timeout
          if (tx_done) begin
            state_q      <= ST_GAP;
            tx_en_q      <= 1'b0;
            frame_done_q <= 1'b1;
          end else if (busy_hit) begin
            state_q <= ST_GAP;
            tx_en_q <= 1'b0;
`ifdef FCP_TX_RETRY_EN
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_q    <= retry_q + 1'b1;
              relaunch_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
`else
            frame_err_q <= 1'b1;
`endif
          end
        end
        ST_GAP: begin
          if (gap_hit) begin
`ifdef FCP_TX_RETRY_EN
            if (relaunch_q) begin
              // resend the captured frame; requests are not re-sampled
              state_q    <= ST_BUSY;
              tx_en_q    <= 1'b1;
              relaunch_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ping_gnt   = ping_gnt_q;
  assign rsp_gnt    = rsp_gnt_q;
  assign tx_en      = tx_en_q;
  assign tx_type    = tx_type_q;
  assign tx_afc     = tx_afc_q;
  assign tx_data    = tx_data_q;
  assign tune_up    = tune_up_q;
  assign tune_cycle = tune_cycle_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fcp_tx_sched.sv
// tb_fcp_tx_sched: randomized frame sequences checked against a frame-level
// model (request priority, captured fields, latched tune, frame length from
// tx_done position vs. timeout, gap length, retry count).
module tb_fcp_tx_sched;

  localparam int GAP = 2;
  localparam int TO  = 64;
`ifdef FCP_TX_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ping_req, rsp_req, rsp_afc;
  logic [15:0] rsp_data;
  logic        cfg_tune_up;
  logic [7:0]  cfg_tune_cycle;
  logic        tx_done;
  logic        ping_gnt, rsp_gnt, tx_en, tx_type, tx_afc;
  logic [15:0] tx_data;
  logic        tune_up;
  logic [7:0]  tune_cycle;
  logic        frame_done, frame_err, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fcp_tx_sched #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO),
`ifdef FCP_TX_RETRY_EN
    .MAX_RETRY     (RETRIES),
`endif
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ping_req      (ping_req),
    .ping_gnt      (ping_gnt),
    .rsp_req       (rsp_req),
    .rsp_afc       (rsp_afc),
    .rsp_data      (rsp_data),
    .rsp_gnt       (rsp_gnt),
    .cfg_tune_up   (cfg_tune_up),
    .cfg_tune_cycle(cfg_tune_cycle),
    .tx_en         (tx_en),
    .tx_type       (tx_type),
    .tx_afc        (tx_afc),
    .tx_data       (tx_data),
    .tune_up       (tune_up),
    .tune_cycle    (tune_cycle),
    .tx_done       (tx_done),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_en"}, tx_en, 0);
    chk({tag, "_tx_type"}, tx_type, 0);
    chk({tag, "_tx_afc"}, tx_afc, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tune"}, {tune_up, tune_cycle}, 0);
    chk({tag, "_gnts"}, {ping_gnt, rsp_gnt}, 0);
    chk({tag, "_frame"}, {frame_done, frame_err}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // frame-level model state
  logic [15:0] exp_data;
  logic        exp_afc, exp_type, exp_tup;
  logic [7:0]  exp_tcyc;
  bit          ping_pending;

  initial begin
    rst = 1'b1; ping_req = 0; rsp_req = 0; rsp_afc = 0; rsp_data = 0;
    cfg_tune_up = 0; cfg_tune_cycle = 0; tx_done = 0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    exp_data = 16'h0;
    ping_pending = 0;

    for (int t = 0; t < 24; t++) begin
      int kind;      // 0 ping, 1 rsp, 2 both
      int done_at;   // BUSY cycle index of tx_done; >= TO means never
      int attempts;
      bit finished;
      if (ping_pending) kind = 0;
      else if (t < 4) kind = t % 3;
      else kind = int'($urandom_range(0, 2));
      case (t)
        0: done_at = 10;
        1: done_at = TO - 1;          // tx_done on the timeout cycle
        2: done_at = TO + 5;          // never: watchdog
        3: done_at = 0;
        default: begin
          int r;
          r = int'($urandom_range(0, 3));
          done_at = (r == 0) ? TO + 1 : (r == 1) ? TO - 1 : int'($urandom_range(0, TO - 2));
        end
      endcase

      chk("pre_busy", busy, 0);
      chk("pre_tx_en", tx_en, 0);

      rsp_req        = (kind != 0);
      ping_req       = (kind != 1);
      rsp_data       = 16'($urandom);
      rsp_afc        = 1'($urandom);
      cfg_tune_up    = 1'($urandom);
      cfg_tune_cycle = 8'($urandom);
      exp_tup  = cfg_tune_up;
      exp_tcyc = cfg_tune_cycle;
      exp_type = (kind != 0);
      if (kind != 0) begin
        exp_data = rsp_data;
        exp_afc  = rsp_afc;
      end else begin
        exp_afc = 1'b0;
      end
      tick();

      chk("rsp_gnt", rsp_gnt, exp_type);
      chk("ping_gnt", ping_gnt, !exp_type);
      chk("accept_tx_en", tx_en, 1);
      chk("accept_busy", busy, 1);
      chk("tx_type", tx_type, exp_type);
      chk("tx_data", tx_data, exp_data);
      chk("tx_afc", tx_afc, exp_afc);
      chk("tune_up", tune_up, exp_tup);
      chk("tune_cycle", tune_cycle, exp_tcyc);

      rsp_req = 0;
      if (kind != 2) ping_req = 0;
      ping_pending = (kind == 2);
      // mid-frame cfg change must not reach tune_* until the next accept
      cfg_tune_up    = ~exp_tup;
      cfg_tune_cycle = exp_tcyc + 8'd4;
      rsp_data       = ~exp_data;

      attempts = 0;
      finished = 0;
      while (!finished) begin
        int  k_end;
        bit  ok, last;
        k_end = (done_at < TO) ? done_at : TO - 1;
        for (int k = 0; k <= k_end; k++) begin
          tx_done = (k == done_at);
          chk("frame_tx_en", tx_en, 1);
          chk("frame_gnts", {ping_gnt, rsp_gnt}, (k == 0) ? {!exp_type && attempts == 0, exp_type && attempts == 0} : 2'b00);
          chk("frame_tune", {tune_up, tune_cycle}, {exp_tup, exp_tcyc});
          tick();
        end
        tx_done = 0;
        ok   = (done_at < TO);
        last = ok || (attempts == RETRIES);
        chk("end_tx_en", tx_en, 0);
        chk("frame_done", frame_done, ok);
        chk("frame_err", frame_err, !ok && last);
        chk("end_busy", busy, 1);
        for (int g = 0; g < GAP; g++) begin
          if (g > 0) begin
            chk("gap_tx_en", tx_en, 0);
            chk("gap_pulses", {frame_done, frame_err, ping_gnt, rsp_gnt}, 0);
            chk("gap_busy", busy, 1);
          end
          tx_done = 1'($urandom);   // stray tx_done outside BUSY is ignored
          tick();
        end
        tx_done = 0;
        if (!last) begin
          attempts++;
          chk("relaunch_tx_en", tx_en, 1);
          chk("relaunch_data", tx_data, exp_data);
          chk("relaunch_type", tx_type, exp_type);
        end else begin
          chk("post_busy", busy, 0);
          chk("post_tx_en", tx_en, 0);
          chk("post_pulses", {frame_done, frame_err}, 0);
          finished = 1;
        end
      end
      $display("[TB] frame %0d kind=%0d done_at=%0d attempts=%0d data=%04h", t, kind, done_at, attempts + 1, exp_data);
    end

    // reset in the middle of BUSY
    rsp_req = 1; rsp_data = 16'hA5C3; rsp_afc = 1; cfg_tune_up = 1; cfg_tune_cycle = 8'd7;
    tick();
    rsp_req = 0;
    chk("rst_pre_tx_en", tx_en, 1);
    repeat (5) tick();
    rst = 1;
    tick();
    chk_all_zero("midreset");
    rst = 0;
    tx_done = 1;
    tick();
    tx_done = 0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_pulse", frame_done, 0);
    $display("[TB] mid-frame reset checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
